// File: rtl/nes_ctrl_reader.sv
//------------------------------------------------------------------------------
// nes_ctrl_reader
//
// Polls two NES game pads (CD4021 parallel-in/serial-out shift registers) and
// publishes each pad's eight buttons as an active-high byte.
//
// Both pads share one FSM, so their latch and clock pins toggle identically.
// Their Q7 lines are sampled in parallel into two independent shift registers.
//
// Frame sequence:
//   LATCH, SETTLE, then 7 x (CLK_HI, CLK_LO).
//   Each of these phases lasts PULSE_CYCLES clocks.
//   A one-cycle DONE state follows, which publishes the data and pulses
//   data_valid.
//
// Between frames the block idles for POLL_CYCLES clocks.
//
// Bit order as shifted out:
//   0=A, 1=B, 2=Select, 3=Start, 4=Up, 5=Down, 6=Left, 7=Right.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module nes_ctrl_reader #(
  parameter int PULSE_CYCLES = 600,      // clocks per latch/clock phase, >= 4
  parameter int POLL_CYCLES  = 1666667   // idle clocks between frames, >= 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ctrl1_q7,
  input  logic       ctrl2_q7,
  output logic       pl1,
  output logic       pl2,
  output logic       nclk1,
  output logic       nclk2,
  output logic [7:0] ctrl1_data,
  output logic [7:0] ctrl2_data,
  output logic       data_valid,
  output logic       busy
);

  // One counter serves both the idle poll interval and the per-phase timing,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (POLL_CYCLES > PULSE_CYCLES) ? POLL_CYCLES : PULSE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_SETTLE,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift1;
  logic [7:0]      shift2;
  logic [1:0]      sync1;      // [0] first stage, [1] stage used for sampling
  logic [1:0]      sync2;
  logic            pl_q;
  logic            nclk_q;

  logic            phase_end;
  logic            poll_end;
  logic            press1;
  logic            press2;

  // The pads share one set of timing registers; both pin pairs are driven
  // from the same flops so they can never drift apart.
  assign pl1   = pl_q;
  assign pl2   = pl_q;
  assign nclk1 = nclk_q;
  assign nclk2 = nclk_q;

  // Bring the asynchronous Q7 lines into the clk domain. The reset value is 1,
  // which matches a released button or an unplugged pad (pull-up).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments let both stages update from the values
      // held before the edge; blocking here would collapse the synchronizer
      // into a single flop.
      sync1 <= {sync1[0], ctrl1_q7};
      sync2 <= {sync2[0], ctrl2_q7};
    end
  end

  // Decode the counter terminal values and convert the active-low pad lines
  // into pressed flags.
  always_comb begin
    // NOTE: every output of this block receives a default first, so no path
    // can leave one unassigned and infer a latch.
    phase_end = 1'b0;
    poll_end  = 1'b0;
    press1    = 1'b0;
    press2    = 1'b0;

    if (cnt == PULSE_LAST) phase_end = 1'b1;
    if (cnt == POLL_LAST)  poll_end  = 1'b1;

    press1 = ~sync1[1];
    press2 = ~sync2[1];
  end

  // Frame sequencer: phase timing, pin generation, sampling and publication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      pl_q       <= 1'b0;
      nclk_q     <= 1'b0;
      busy       <= 1'b0;
      data_valid <= 1'b0;
      ctrl1_data <= '0;
      ctrl2_data <= '0;
      // NOTE: the working shift registers are reset as well. Their contents
      // are always overwritten before use, but clearing them keeps state
      // deterministic after a mid-frame reset.
      shift1     <= '0;
      shift2     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (poll_end) begin
            cnt   <= '0;
            pl_q  <= 1'b1;
            busy  <= 1'b1;
            state <= S_LATCH;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Pads capture their buttons while pl is high.
        S_LATCH: begin
          if (phase_end) begin
            cnt   <= '0;
            pl_q  <= 1'b0;
            state <= S_SETTLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Bit 0 (A) is already present on Q7 once the latch drops.
        S_SETTLE: begin
          if (phase_end) begin
            cnt       <= '0;
            shift1[0] <= press1;
            shift2[0] <= press2;
            bit_idx   <= 3'd1;
            nclk_q    <= 1'b1;
            state     <= S_CLK_HI;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // The rising nclk edge at entry moves the next bit onto Q7.
        S_CLK_HI: begin
          if (phase_end) begin
            cnt    <= '0;
            nclk_q <= 1'b0;
            state  <= S_CLK_LO;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Sample late in the low phase, well after the shift has settled.
        S_CLK_LO: begin
          if (phase_end) begin
            cnt             <= '0;
            shift1[bit_idx] <= press1;
            shift2[bit_idx] <= press2;

            if (bit_idx == 3'd7) begin
              // Publish the complete byte together with the valid strobe, so
              // both become visible during the single DONE cycle.
              ctrl1_data <= {press1, shift1[6:0]};
              ctrl2_data <= {press2, shift2[6:0]};
              data_valid <= 1'b1;
              busy       <= 1'b0;
              state      <= S_DONE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              nclk_q  <= 1'b1;
              state   <= S_CLK_HI;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          data_valid <= 1'b0;
          cnt        <= '0;
          bit_idx    <= '0;
          state      <= S_IDLE;
        end

        default: begin
          cnt        <= '0;
          bit_idx    <= '0;
          pl_q       <= 1'b0;
          nclk_q     <= 1'b0;
          busy       <= 1'b0;
          data_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_ctrl_reader.sv
//------------------------------------------------------------------------------
// tb_nes_ctrl_reader
//
// Two behavioural CD4021 pad models feed the reader.
//
// The scoreboard records each pad's buttons at the moment the latch drops.
// It expects exactly that byte at the next data_valid.
//
// A cycle monitor checks the pin timing against the frame rules:
//   - latch/clock phase widths,
//   - nclk count,
//   - frame length and period,
//   - idle gap,
//   - exclusivity of pl and nclk,
//   - busy,
//   - data hold.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_nes_ctrl_reader;

  localparam int P      = 4;
  localparam int POLL   = 100;
  localparam int FRAME  = 16 * P;
  localparam int PERIOD = FRAME + 1 + POLL;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       ctrl1_q7;
  logic       ctrl2_q7;
  logic       pl1, pl2, nclk1, nclk2;
  logic [7:0] ctrl1_data, ctrl2_data;
  logic       data_valid, busy;

  nes_ctrl_reader #(
    .PULSE_CYCLES (P),
    .POLL_CYCLES  (POLL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ctrl1_q7   (ctrl1_q7),
    .ctrl2_q7   (ctrl2_q7),
    .pl1        (pl1),
    .pl2        (pl2),
    .nclk1      (nclk1),
    .nclk2      (nclk2),
    .ctrl1_data (ctrl1_data),
    .ctrl2_data (ctrl2_data),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  //----------------------------------------------------------------------------
  // CD4021 pad models.
  // Buttons are active-high here and presented active-low on the pins.
  // The high pl level loads the pad; each nclk rise shifts in a 1 from the
  // serial input.
  //----------------------------------------------------------------------------
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [7:0] sr1  = 8'hFF, sr2  = 8'hFF;
  logic       g1   = 1'b0,  g2   = 1'b0;
  logic       glitch_en = 1'b0;

  always @(posedge pl1 or posedge nclk1)
    if (pl1) sr1 <= ~btn1;
    else     sr1 <= {1'b1, sr1[7:1]};

  always @(posedge pl2 or posedge nclk2)
    if (pl2) sr2 <= ~btn2;
    else     sr2 <= {1'b1, sr2[7:1]};

  assign ctrl1_q7 = sr1[0] ^ g1;
  assign ctrl2_q7 = sr2[0] ^ g2;

  // Single-cycle glitches.
  // They occur only while nclk is high or the reader is idle, which is far
  // from any sampling point.
  always @(negedge clk) begin
    g1 = glitch_en && (nclk1 || !busy) && !g1 && ($urandom_range(0, 2) == 0);
    g2 = glitch_en && (nclk2 || !busy) && !g2 && ($urandom_range(0, 2) == 0);
  end

  //----------------------------------------------------------------------------
  // Cycle monitor and scoreboard.
  //----------------------------------------------------------------------------
  int         cyc = 0;
  int         rel_cyc = 0;
  int         pl_rise_cyc = 0, nclk_hi_cyc = 0, nclk_lo_cyc = 0, last_dv_cyc = 0;
  int         nclk_rises = 0;
  bit         in_frame = 0, first_latch_pending = 1, have_last_dv = 0;
  bit         pl_q = 0, nclk_q = 0, dv_q = 0;
  logic [7:0] exp1_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] pub1 = 8'h00, pub2 = 8'h00;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      in_frame            = 0;
      first_latch_pending = 1;
      have_last_dv        = 0;
      nclk_rises          = 0;
      pl_q                = 0;
      nclk_q              = 0;
      dv_q                = 0;
      pub1                = 8'h00;
      pub2                = 8'h00;
      exp1_q.delete();
      exp2_q.delete();
    end else begin
      // pl rise marks the start of a frame.
      if (pl1 && !pl_q) begin
        if (first_latch_pending)
          check("first_latch_gap", cyc - rel_cyc, POLL);
        else if (have_last_dv)
          check("idle_gap", cyc - last_dv_cyc, POLL + 1);
        first_latch_pending = 0;
        pl_rise_cyc         = cyc;
        in_frame            = 1;
        nclk_rises          = 0;
      end

      // pl fall: the pads hold the buttons captured during the latch.
      if (!pl1 && pl_q) begin
        check("pl_width", cyc - pl_rise_cyc, P);
        exp1_q.push_back(btn1);
        exp2_q.push_back(btn2);
        nclk_lo_cyc = cyc;
      end

      if (nclk1 && !nclk_q) begin
        check("nclk_in_frame", 32'(in_frame), 1);
        check("nclk_lo_width", cyc - nclk_lo_cyc, P);
        nclk_rises++;
        nclk_hi_cyc = cyc;
      end

      if (!nclk1 && nclk_q) begin
        check("nclk_hi_width", cyc - nclk_hi_cyc, P);
        nclk_lo_cyc = cyc;
      end

      if (data_valid) begin
        check("frame_len", cyc - pl_rise_cyc, FRAME);
        check("nclk_count", nclk_rises, 7);
        if (have_last_dv) check("dv_period", cyc - last_dv_cyc, PERIOD);
        if (exp1_q.size() == 0 || exp2_q.size() == 0) begin
          check("sb_expectation_present", 0, 1);
        end else begin
          pub1 = exp1_q.pop_front();
          pub2 = exp2_q.pop_front();
          check("sb_pad1", 32'(ctrl1_data), 32'(pub1));
          check("sb_pad2", 32'(ctrl2_data), 32'(pub2));
        end
        last_dv_cyc  = cyc;
        have_last_dv = 1;
        in_frame     = 0;
      end else begin
        check("hold_pad1", 32'(ctrl1_data), 32'(pub1));
        check("hold_pad2", 32'(ctrl2_data), 32'(pub2));
      end

      check("busy", 32'(busy), 32'(in_frame));
      check("pl_nclk_exclusive", 32'(pl1 & nclk1), 0);
      check("pins_match", 32'({pl1, nclk1}), 32'({pl2, nclk2}));
      check("dv_single_cycle", 32'(dv_q & data_valid), 0);

      pl_q   = pl1;
      nclk_q = nclk1;
      dv_q   = data_valid;
    end
  end

  //----------------------------------------------------------------------------
  // Stimulus helpers.
  //----------------------------------------------------------------------------
  task automatic wait_dv();
    bit seen = 0;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      @(negedge clk);
      #1;
      if (data_valid) seen = 1;
    end
    if (!seen) check("dv_timeout", 0, 1);
  endtask

  task automatic wait_nclk(input int n);
    bit seen = 0;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      @(negedge clk);
      #1;
      if (in_frame && nclk_rises == n && nclk1) seen = 1;
    end
    if (!seen) check("nclk_timeout", 0, 1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    reset   = 1'b0;
    rel_cyc = cyc;
  endtask

  logic [7:0] new1;

  initial begin
    // Reset state.
    #1 reset = 1'b1;
    #3;
    check("rst_pins", 32'({pl1, pl2, nclk1, nclk2}), 0);
    check("rst_status", 32'({data_valid, busy}), 0);
    check("rst_data", 32'({ctrl1_data, ctrl2_data}), 0);
    repeat (3) @(negedge clk);
    release_reset();

    // Nothing pressed (or unplugged): both bytes read 0.
    wait_dv();
    check("idle_pad1", 32'(ctrl1_data), 32'h00);
    check("idle_pad2", 32'(ctrl2_data), 32'h00);
    wait_dv();

    // A+Right on pad 1, Start+Up on pad 2, published in the same frame.
    btn1 = 8'h81;
    btn2 = 8'h18;
    wait_dv();
    check("pad1_a_right", 32'(ctrl1_data), 32'h81);
    check("pad2_start_up", 32'(ctrl2_data), 32'h18);

    // Change the buttons after the 3rd nclk; the old latch must still publish.
    new1 = (8'($urandom) & 8'h7E) | 8'h02;
    wait_nclk(3);
    btn1 = new1;
    btn2 = 8'($urandom);
    check("midframe_hold", 32'(ctrl1_data), 32'h81);
    wait_dv();
    check("midframe_old", 32'(ctrl1_data), 32'h81);
    wait_dv();
    check("midframe_new", 32'(ctrl1_data), 32'(new1));

    // Reset during CLK_HI of bit 4: everything drops with no clock edge.
    wait_nclk(4);
    check("pre_reset_nclk", 32'(nclk1), 1);
    #2 reset = 1'b1;
    #1;
    check("async_pins", 32'({pl1, pl2, nclk1, nclk2}), 0);
    check("async_status", 32'({data_valid, busy}), 0);
    check("async_data", 32'({ctrl1_data, ctrl2_data}), 0);
    repeat (2) @(negedge clk);
    release_reset();
    wait_dv();
    check("post_reset_pad1", 32'(ctrl1_data), 32'(btn1));
    check("post_reset_pad2", 32'(ctrl2_data), 32'(btn2));

    // Randomized frames with Q7 glitches away from the sample points.
    glitch_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        btn1 = 8'hFF;
        btn2 = 8'h80;
      end else begin
        btn1 = 8'($urandom);
        btn2 = 8'($urandom);
      end
      wait_dv();
      check("rand_pad1", 32'(ctrl1_data), 32'(btn1));
      check("rand_pad2", 32'(ctrl2_data), 32'(btn2));
    end
    glitch_en = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
